// File: rtl/ram_stream_pkg.sv
// Shared definitions for the RAM stream reader.
//   state_e    : sequencer states (IDLE, RUN, DRAIN)
//   BUF_DEPTH  : output buffer depth (2 covers the 1-cycle read latency)
//   eff_count  : number of words actually readable for a request
package ram_stream_pkg;

    localparam int unsigned BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    // Words that fit inside the RAM. The subtraction is only evaluated when
    // base lies inside the RAM, so it never underflows.
    function automatic logic [31:0] eff_count(input logic [31:0] base,
                                              input logic [31:0] count,
                                              input logic [31:0] len);
        logic [31:0] room;
        if (base >= len) begin
            return '0;
        end
        room = len - base;
        return (count < room) ? count : room;
    endfunction

endpackage

// File: rtl/stream_buffer2.sv
// Two-entry synchronous FIFO holding words returned by the RAM.
//   clk, reset  : rising-edge clock, synchronous active-low reset
//   push        : write push_data this cycle
//   pop         : drop the head entry this cycle (caller ensures !empty)
//   pop_data    : head entry (0 after reset)
//   empty/count : occupancy status
// Push and pop in the same cycle leave the occupancy unchanged.
module stream_buffer2 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic [1:0]       count
);
    import ram_stream_pkg::*;

    logic [WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [WIDTH-1:0] mem_d [BUF_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/ram_stream_reader.sv
// Read sequencer for one port of a dual-port RAM with 1-cycle registered reads.
// On start it reads base..base+n-1 (n clipped to the RAM length) and streams
// the words in order on a valid/ready interface with full backpressure.
//   start/base/count/ram_length : command, latched in IDLE
//   busy/done/clipped           : status (registered)
//   ram_*                       : RAM read port (write side tied off)
//   out_valid/out_ready/out_data: output stream
module ram_stream_reader #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      base,
    input  logic [31:0]      count,
    output logic             busy,
    output logic             done,
    output logic             clipped,
    output logic [31:0]      ram_address,
    output logic             ram_oe,
    output logic             ram_we,
    output logic [WIDTH-1:0] ram_din,
    input  logic [WIDTH-1:0] ram_dout,
    input  logic [31:0]      ram_length,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    import ram_stream_pkg::*;

    localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] remaining_q, remaining_d;
    logic        inflight_q, inflight_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        clipped_q, clipped_d;

    logic        pop;
    logic        issue;
    logic        fifo_empty;
    logic [1:0]  fifo_count;
    logic [2:0]  occ_net;
    logic [2:0]  occ_after;
    logic [31:0] eff;

    always_comb begin
        pop       = !fifo_empty && out_ready;
        // Credit uses occupancy net of this cycle's pop so a steady stream
        // with out_ready high can issue every cycle; the word freed by the
        // pop is exactly the slot the new read will land in.
        occ_net   = {1'b0, fifo_count} - {2'b0, pop};
        occ_after = occ_net + {2'b0, inflight_q};
        issue     = (state_q == RUN) && (remaining_q != '0) && (occ_after < CREDIT);
        eff       = eff_count(base, count, ram_length);

        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        busy_d      = busy_q;
        done_d      = 1'b0;
        clipped_d   = clipped_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    addr_d      = base;
                    remaining_d = eff;
                    clipped_d   = (eff < count);
                    if (eff == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        busy_d  = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    addr_d      = addr_q + 32'd1;
                    remaining_d = remaining_q - 32'd1;
                    if (remaining_q == 32'd1) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave when the buffer will be empty after this edge; done
                // and the falling busy then appear together next cycle.
                if (occ_after == 3'd0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            clipped_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            clipped_q   <= clipped_d;
        end
    end

    stream_buffer2 #(
        .WIDTH(WIDTH)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .push     (inflight_q),
        .push_data(ram_dout),
        .pop      (pop),
        .pop_data (out_data),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign clipped     = clipped_q;
    assign ram_address = addr_q;
    assign ram_oe      = issue;
    assign ram_we      = 1'b0;
    assign ram_din     = '0;
    assign out_valid   = !fifo_empty;

endmodule
